// File: rtl/encode_8b10b_multi.sv
// ----------------------------------------------------------------------------
// encode_8b10b_multi
//
// Multi-lane IBM 8b/10b encoder with control-character (K) support and a
// valid/ready stream interface. LANES bytes are encoded per clock. Running
// disparity ripples lane 0 -> lane LANES-1 inside a word and the exit
// disparity of the last lane is carried into the next word through rd.
//
// Parameters:
//   LANES    bytes encoded per clock (1..8)
//   RD_INIT  running disparity after reset (0 = RD-, 1 = RD+)
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_valid       input word valid
//   in_ready       encoder can accept a word (out_ready | ~out_valid)
//   in_data        lane n byte at [8n+7:8n] (HGF EDCBA = [7:5] [4:0])
//   in_k           lane n is a control character
//   out_valid      out_data valid
//   out_ready      downstream accepts
//   out_data       lane n symbol at [10n+9:10n], {fghj, abcdei}, f at bit 9
//   out_k          registered copy of in_k
//   out_code_err   lane n requested an illegal K code (encoded as D instead)
//   rd             current running disparity (1 = RD+)
//
// Optional build macro:
//   ENC8B10B_IDLE_COMMA_EN  when defined, every idle cycle (in_ready=1,
//                           in_valid=0) loads K28.5 on all lanes, so the
//                           output stream never goes invalid after reset.
// ----------------------------------------------------------------------------
module encode_8b10b_multi #(
    parameter int LANES   = 2,
    parameter bit RD_INIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [LANES-1:0]     in_k,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [10*LANES-1:0]  out_data,
    output logic [LANES-1:0]     out_k,
    output logic [LANES-1:0]     out_code_err,
    output logic                 rd
);

    // 5b/6b table, RD- column, abcdei with a in bit 5.
    function automatic logic [5:0] d6_rdm(input logic [4:0] x);
        case (x)
            5'd0:  d6_rdm = 6'b100111;  5'd1:  d6_rdm = 6'b011101;
            5'd2:  d6_rdm = 6'b101101;  5'd3:  d6_rdm = 6'b110001;
            5'd4:  d6_rdm = 6'b110101;  5'd5:  d6_rdm = 6'b101001;
            5'd6:  d6_rdm = 6'b011001;  5'd7:  d6_rdm = 6'b111000;
            5'd8:  d6_rdm = 6'b111001;  5'd9:  d6_rdm = 6'b100101;
            5'd10: d6_rdm = 6'b010101;  5'd11: d6_rdm = 6'b110100;
            5'd12: d6_rdm = 6'b001101;  5'd13: d6_rdm = 6'b101100;
            5'd14: d6_rdm = 6'b011100;  5'd15: d6_rdm = 6'b010111;
            5'd16: d6_rdm = 6'b011011;  5'd17: d6_rdm = 6'b100011;
            5'd18: d6_rdm = 6'b010011;  5'd19: d6_rdm = 6'b110010;
            5'd20: d6_rdm = 6'b001011;  5'd21: d6_rdm = 6'b101010;
            5'd22: d6_rdm = 6'b011010;  5'd23: d6_rdm = 6'b111010;
            5'd24: d6_rdm = 6'b110011;  5'd25: d6_rdm = 6'b100110;
            5'd26: d6_rdm = 6'b010110;  5'd27: d6_rdm = 6'b110110;
            5'd28: d6_rdm = 6'b001110;  5'd29: d6_rdm = 6'b101110;
            5'd30: d6_rdm = 6'b011110;  default: d6_rdm = 6'b101011;
        endcase
    endfunction

    // 3b/4b table, RD- column, fghj with f in bit 3 (y=7 is the primary P7).
    function automatic logic [3:0] d4_rdm(input logic [2:0] y);
        case (y)
            3'd0: d4_rdm = 4'b1011;  3'd1: d4_rdm = 4'b1001;
            3'd2: d4_rdm = 4'b0101;  3'd3: d4_rdm = 4'b1100;
            3'd4: d4_rdm = 4'b1101;  3'd5: d4_rdm = 4'b1010;
            3'd6: d4_rdm = 4'b0110;  default: d4_rdm = 4'b1110;
        endcase
    endfunction

    // Returns {code_err, exit_rd, fghj[3:0], abcdei[5:0]} for one lane.
    function automatic logic [11:0] encode_lane(input logic [7:0] b,
                                                input logic       k,
                                                input logic       rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic       legal_k, k28, unb6, unb4, rd_mid, use_a7;
        logic [5:0] s6;
        logic [3:0] s4;
        x       = b[4:0];
        y       = b[7:5];
        legal_k = k && (x == 5'd28 || (y == 3'd7 && (x == 5'd23 || x == 5'd27 ||
                                                     x == 5'd29 || x == 5'd30)));
        k28     = legal_k && (x == 5'd28);

        s6   = k28 ? 6'b001111 : d6_rdm(x);
        unb6 = ($countones(s6) != 3);
        // D.7 is balanced yet still swaps form at RD+.
        if (rd_in && (unb6 || s6 == 6'b111000))
            s6 = ~s6;
        rd_mid = rd_in ^ unb6;

        // A7 replaces P7 wherever P7 would create a run of five equal bits.
        use_a7 = (y == 3'd7) && (legal_k ||
                 (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                 ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        s4   = use_a7 ? 4'b0111 : d4_rdm(y);
        unb4 = ($countones(s4) != 2);
        if (rd_mid && (unb4 || s4 == 4'b1100))
            s4 = ~s4;
        // K28 balanced sub-blocks invert after the RD+ 110000 prefix so the
        // comma pattern stays distinct from any data sequence.
        else if (k28 && rd_in && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6))
            s4 = ~s4;

        encode_lane = {k && !legal_k, rd_mid ^ unb4, s4, s6};
    endfunction

    logic                 out_valid_q, out_valid_d;
    logic [10*LANES-1:0]  out_data_q,  out_data_d;
    logic [LANES-1:0]     out_k_q,     out_k_d;
    logic [LANES-1:0]     out_err_q,   out_err_d;
    logic                 rd_q,        rd_d;

    logic                 load;
    logic [8*LANES-1:0]   src_data;
    logic [LANES-1:0]     src_k;
    logic [10*LANES-1:0]  enc_data;
    logic [LANES-1:0]     enc_err;
    logic                 lane_rd;
    logic [11:0]          lane_res;

    assign in_ready = out_ready | ~out_valid_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_k_d     = out_k_q;
        out_err_d   = out_err_q;
        rd_d        = rd_q;
        src_data    = in_data;
        src_k       = in_k;
        load        = in_valid & in_ready;
        enc_data    = '0;
        enc_err     = '0;
        lane_res    = '0;

`ifdef ENC8B10B_IDLE_COMMA_EN
        if (!in_valid) begin
            src_data = {LANES{8'hBC}};
            src_k    = '1;
        end
        load = in_ready;
`endif

        // Disparity ripples through the lanes of one word.
        lane_rd = rd_q;
        for (int n = 0; n < LANES; n++) begin
            lane_res              = encode_lane(src_data[8*n +: 8], src_k[n], lane_rd);
            enc_data[10*n +: 10]  = lane_res[9:0];
            enc_err[n]            = lane_res[11];
            lane_rd               = lane_res[10];
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = enc_data;
            out_k_d     = src_k;
            out_err_d   = enc_err;
            rd_d        = lane_rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_k_q     <= '0;
            out_err_q   <= '0;
            rd_q        <= RD_INIT;
        end else begin
            // NOTE: non-blocking updates so every flop samples the values
            // from before this edge.
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_k_q     <= out_k_d;
            out_err_q   <= out_err_d;
            rd_q        <= rd_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_k        = out_k_q;
    assign out_code_err = out_err_q;
    assign rd           = rd_q;

endmodule
